// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns framed host commands from the UART receiver into
// single-byte EEPROM read/write operations. Optional inter-byte timeout is
// built only when CMD_TIMEOUT_EN is defined.
//
// Frame: HEADER, CMD (01 = WR, 02 = RD), ADDR, LEN, DATA[LEN] (WR only), CHK.
// CHK is the XOR of CMD, ADDR, LEN and every DATA byte. Write payload is
// buffered and nothing is issued until the checksum has been confirmed, so a
// corrupted frame never reaches the EEPROM controller.
module uart_cmd_parser #(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_vld,
  output logic       op_vld,
  input  logic       op_rdy,
  output logic       op_rw,
  output logic [7:0] op_addr,
  output logic [7:0] op_wdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  // Operation counter must hold the value LEN itself (1..MAX_LEN).
  localparam int CW = $clog2(MAX_LEN + 1);
  // Buffer index only needs to address entries 0..MAX_LEN-1.
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_CHK = 2'd0;
  localparam logic [1:0] ERR_CMD = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_LEN   = 3'd3,
    S_DATA  = 3'd4,
    S_CHK   = 3'd5,
    S_ISSUE = 3'd6
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t         state_q;
  logic           rw_q;          // 1 = read frame
  logic [7:0]     addr_q;        // start address from the frame
  logic [CW-1:0]  len_q;         // operation count from the frame
  logic [CW-1:0]  idx_q;         // payload index while parsing, op index while issuing
  logic [7:0]     chk_q;         // running XOR of the frame body

  logic           op_vld_q;
  logic           op_rw_q;
  logic [7:0]     op_addr_q;
  logic [7:0]     op_wdata_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;
  logic [1:0]     err_code_q;

  // Write payload; contents are don't-care outside a WR frame so no reset.
  logic [7:0]     buf_q [0:MAX_LEN-1];

  // ---------------------------------------------------------------------
  // Next-state helpers
  // ---------------------------------------------------------------------
  logic [CW-1:0]  idx_inc_d;
  logic           idx_last_d;
  logic [7:0]     chk_nxt_d;
  logic           cmd_ok_d;
  logic           len_bad_d;
  logic [7:0]     buf_nxt_d;
  logic           tmo_hit_d;

  assign idx_inc_d  = idx_q + 1'b1;
  assign idx_last_d = (idx_inc_d == len_q);
  assign chk_nxt_d  = chk_q ^ rx_data;
  assign cmd_ok_d   = (rx_data == CMD_WR) || (rx_data == CMD_RD);
  assign len_bad_d  = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
  // Payload byte for the operation after the one being accepted; only used
  // when that operation exists, so the index is always in range.
  assign buf_nxt_d  = buf_q[idx_inc_d[AW-1:0]];

  // ---------------------------------------------------------------------
  // Optional inter-byte timeout
  // ---------------------------------------------------------------------
`ifdef CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TW-1:0] tmo_q;
  logic          in_parse_d;

  assign in_parse_d = (state_q == S_CMD)  || (state_q == S_ADDR) ||
                      (state_q == S_LEN)  || (state_q == S_DATA) ||
                      (state_q == S_CHK);
  assign tmo_hit_d  = in_parse_d && !rx_vld && (tmo_q == TW'(TIMEOUT - 1));

  // Count idle cycles between bytes while a frame is being parsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (!in_parse_d || rx_vld || tmo_hit_d) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  // Without the timeout the parser waits indefinitely for the next byte.
  assign tmo_hit_d = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Payload buffer
  // ---------------------------------------------------------------------
  // Capture write payload bytes in arrival order.
  always_ff @(posedge clk) begin
    if ((state_q == S_DATA) && rx_vld) begin
      buf_q[idx_q[AW-1:0]] <= rx_data;
    end
  end

  // ---------------------------------------------------------------------
  // Parser / issue FSM
  // ---------------------------------------------------------------------
  // Frame parsing, checksum verification and operation handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rw_q       <= 1'b0;
      addr_q     <= 8'd0;
      len_q      <= '0;
      idx_q      <= '0;
      chk_q      <= 8'd0;
      op_vld_q   <= 1'b0;
      op_rw_q    <= 1'b0;
      op_addr_q  <= 8'd0;
      op_wdata_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      // done and err are single-cycle pulses.
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (tmo_hit_d) begin
        // Host went quiet mid-frame: drop the partial frame.
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        err_q      <= 1'b1;
        err_code_q <= ERR_TMO;
      end else begin
        case (state_q)
          S_IDLE: begin
            // Anything other than the header is line noise and is ignored.
            if (rx_vld && (rx_data == HEADER)) begin
              state_q <= S_CMD;
              busy_q  <= 1'b1;
              chk_q   <= 8'd0;
              idx_q   <= '0;
            end
          end

          S_CMD: begin
            if (rx_vld) begin
              if (cmd_ok_d) begin
                state_q <= S_ADDR;
                rw_q    <= (rx_data == CMD_RD);
                chk_q   <= chk_nxt_d;
              end else begin
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                err_code_q <= ERR_CMD;
              end
            end
          end

          S_ADDR: begin
            if (rx_vld) begin
              state_q <= S_LEN;
              addr_q  <= rx_data;
              chk_q   <= chk_nxt_d;
            end
          end

          S_LEN: begin
            if (rx_vld) begin
              if (len_bad_d) begin
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                err_code_q <= ERR_LEN;
              end else begin
                // Range check above guarantees the value fits in CW bits.
                len_q   <= rx_data[CW-1:0];
                chk_q   <= chk_nxt_d;
                idx_q   <= '0;
                state_q <= rw_q ? S_CHK : S_DATA;
              end
            end
          end

          S_DATA: begin
            // A HEADER-valued byte here is ordinary payload, not a resync.
            if (rx_vld) begin
              chk_q <= chk_nxt_d;
              if (idx_last_d) begin
                idx_q   <= '0;
                state_q <= S_CHK;
              end else begin
                idx_q <= idx_inc_d;
              end
            end
          end

          S_CHK: begin
            if (rx_vld) begin
              if (rx_data == chk_q) begin
                state_q <= S_ISSUE;
                idx_q   <= '0;
              end else begin
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                err_code_q <= ERR_CHK;
              end
            end
          end

          S_ISSUE: begin
            // Incoming bytes are dropped here; only the handshake matters.
            if (!op_vld_q) begin
              // First cycle in ISSUE: present operation 0.
              op_vld_q   <= 1'b1;
              op_rw_q    <= rw_q;
              op_addr_q  <= addr_q;
              op_wdata_q <= rw_q ? 8'd0 : buf_q[0];
            end else if (op_rdy) begin
              if (idx_last_d) begin
                op_vld_q   <= 1'b0;
                op_rw_q    <= 1'b0;
                op_addr_q  <= 8'd0;
                op_wdata_q <= 8'd0;
                idx_q      <= '0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                state_q    <= S_IDLE;
              end else begin
                // Back-to-back: next operation is presented immediately.
                idx_q      <= idx_inc_d;
                op_addr_q  <= op_addr_q + 8'd1;
                op_wdata_q <= op_rw_q ? 8'd0 : buf_nxt_d;
              end
            end
          end

          default: begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            op_vld_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign op_vld   = op_vld_q;
  assign op_rw    = op_rw_q;
  assign op_addr  = op_addr_q;
  assign op_wdata = op_wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: table of frames with hand-computed
// expected operations/errors, plus sequences for ISSUE-time bytes, reset
// during ISSUE and the inter-byte stall (with or without CMD_TIMEOUT_EN).
module tb_uart_cmd_parser;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       op_vld;
  logic       op_rdy;
  logic       op_rw;
  logic [7:0] op_addr;
  logic [7:0] op_wdata;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  uart_cmd_parser #(
    .MAX_LEN (MAX_LEN),
    .HEADER  (8'hA5),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_vld   (rx_vld),
    .op_vld   (op_vld),
    .op_rdy   (op_rdy),
    .op_rw    (op_rw),
    .op_addr  (op_addr),
    .op_wdata (op_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  // One frame and its expected outcome. Bytes, addresses and data are
  // written left to right (first byte in the most significant position).
  typedef struct packed {
    logic [63:0] bytes;
    logic [3:0]  n;
    logic [3:0]  stall;
    logic [3:0]  nops;
    logic        rw;
    logic [31:0] addrs;
    logic [31:0] datas;
    logic        e;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mkv(input logic [63:0] bytes, input int n, input int stall,
                               input int nops, input logic rw, input logic [31:0] addrs,
                               input logic [31:0] datas, input logic e, input logic [1:0] code);
    vec_t v;
    v.bytes = bytes;
    v.n     = 4'(n);
    v.stall = 4'(stall);
    v.nops  = 4'(nops);
    v.rw    = rw;
    v.addrs = addrs;
    v.datas = datas;
    v.e     = e;
    v.code  = code;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    tick();
    rx_vld  = 1'b0;
    rx_data = 8'h00;
  endtask

  // Handshake all expected operations of v, stalling op_rdy v.stall cycles
  // before each acceptance and checking the fields every cycle.
  task automatic run_ops(input vec_t v);
    int n   = 0;
    int sc  = 0;
    int cyc = 0;
    op_rdy = (v.stall == 0);
    while (n < int'(v.nops) && cyc < 400) begin
      if (op_vld) begin
        chk("op_rw", op_rw, v.rw);
        chk("op_addr", op_addr, v.addrs[31-8*n -: 8]);
        chk("op_wdata", op_wdata, v.rw ? 8'h00 : v.datas[31-8*n -: 8]);
        chk("busy_issue", busy, 1);
        if (sc == int'(v.stall)) begin
          op_rdy = 1'b1;
          tick();
          op_rdy = (v.stall == 0);
          n++;
          sc = 0;
        end else begin
          op_rdy = 1'b0;
          tick();
          sc++;
        end
      end else begin
        tick();
      end
      cyc++;
    end
    chk("op_count", n, v.nops);
    chk("done_after_last", done, 1);
    chk("busy_after_last", busy, 0);
    chk("op_vld_after_last", op_vld, 0);
    chk("no_err_with_done", err, 0);
    op_rdy = 1'b0;
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  // Send a frame from the table and check its outcome.
  task automatic run_frame(input vec_t v);
    logic [7:0] b;
    for (int i = 0; i < int'(v.n); i++) begin
      b = v.bytes[63-8*i -: 8];
      send_byte(b);
      if (i < int'(v.n) - 1) chk("no_err_mid_frame", err, 0);
      if (i == 0 && b == 8'hA5) chk("busy_on_header", busy, 1);
    end
    chk("err_at_end", err, v.e);
    if (v.e) begin
      chk("err_code", err_code, v.code);
      chk("busy_after_err", busy, 0);
    end
    if (v.nops != 0) begin
      chk("busy_before_issue", busy, 1);
      chk("op_vld_latency0", op_vld, 0);
      tick();
      chk("op_vld_latency1", op_vld, 1);
      run_ops(v);
    end else begin
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("no_op_vld", op_vld, 0);
        chk("no_done", done, 0);
        chk("err_one_cycle", err, 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vx;
    logic seen;
    logic [1:0] seen_code;

    //                bytes                      n  st ops rw addrs         datas         e  code
    vecs[0] = mkv(64'hA5_01_10_02_11_22_20_00, 7, 0, 2, 0, 32'h10_11_00_00, 32'h11_22_00_00, 0, 2'd0);
    vecs[1] = mkv(64'hA5_02_FE_03_FF_00_00_00, 5, 5, 3, 1, 32'hFE_FF_00_00, 32'h0,           0, 2'd0);
    vecs[2] = mkv(64'hA5_01_10_02_11_22_21_00, 7, 0, 0, 0, 32'h0,           32'h0,           1, 2'd0);
    vecs[3] = mkv(64'hA5_01_10_02_11_22_20_00, 7, 0, 2, 0, 32'h10_11_00_00, 32'h11_22_00_00, 0, 2'd0);
    vecs[4] = mkv(64'h00_FF_13_A5_07_00_00_00, 5, 0, 0, 0, 32'h0,           32'h0,           1, 2'd1);
    vecs[5] = mkv(64'hA5_01_10_00_00_00_00_00, 4, 0, 0, 0, 32'h0,           32'h0,           1, 2'd2);
    vecs[6] = mkv(64'hA5_02_10_11_00_00_00_00, 4, 0, 0, 0, 32'h0,           32'h0,           1, 2'd2);
    vecs[7] = mkv(64'hA5_01_20_01_A5_85_00_00, 6, 2, 1, 0, 32'h20_00_00_00, 32'hA5_00_00_00, 0, 2'd0);
    vecs[8] = mkv(64'hA5_02_7F_01_7C_00_00_00, 5, 0, 1, 1, 32'h7F_00_00_00, 32'h0,           0, 2'd0);
    vecs[9] = mkv(64'hA5_01_10_07_00_00_00_00, 4, 0, 0, 0, 32'h0,           32'h0,           1, 2'd1);
    // vecs[9] re-checks err_code moving from 2 back to a bad-CMD frame below.
    vecs[9] = mkv(64'hA5_05_00_00_00_00_00_00, 2, 0, 0, 0, 32'h0,           32'h0,           1, 2'd1);

    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_vld  = 1'b0;
    op_rdy  = 1'b0;
    #1;
    chk("rst_op_vld", op_vld, 0);
    chk("rst_op_rw", op_rw, 0);
    chk("rst_op_addr", op_addr, 0);
    chk("rst_op_wdata", op_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i]);
      if (i == 6) begin
        repeat (5) tick();
        chk("err_code_holds", err_code, 2);
        chk("err_idle_low", err, 0);
      end
    end

    // Bytes arriving during ISSUE are dropped; the next frame still parses.
    op_rdy = 1'b0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h30);
    send_byte(8'h02); send_byte(8'h30);
    tick();
    chk("issue_vld", op_vld, 1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h30);
    chk("drop_vld", op_vld, 1);
    chk("drop_addr", op_addr, 8'h30);
    chk("drop_no_err", err, 0);
    vx = mkv(64'h0, 0, 0, 2, 1, 32'h30_31_00_00, 32'h0, 0, 2'd0);
    run_ops(vx);
    run_frame(vecs[0]);

    // Reset while an operation is pending.
    op_rdy = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h40);
    send_byte(8'h01); send_byte(8'h55); send_byte(8'h15);
    tick();
    chk("pre_rst_vld", op_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", op_vld, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_vld", op_vld, 0);
    run_frame(vecs[0]);

    // Long stall after CMD.
    send_byte(8'hA5);
    send_byte(8'h01);
    seen      = 1'b0;
    seen_code = 2'd0;
    for (int k = 0; k < 110; k++) begin
      tick();
      if (err) begin
        seen      = 1'b1;
        seen_code = err_code;
      end
    end
`ifdef CMD_TIMEOUT_EN
    chk("tmo_err", seen, 1);
    chk("tmo_code", seen_code, 3);
    chk("tmo_busy", busy, 0);
    run_frame(vecs[0]);
`else
    chk("stall_no_err", seen, 0);
    chk("stall_busy", busy, 1);
    send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h20);
    chk("stall_frame_err", err, 0);
    chk("stall_lat0", op_vld, 0);
    tick();
    chk("stall_lat1", op_vld, 1);
    run_ops(vecs[0]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver; consumes its byte stream (8-bit byte plus one-cycle valid pulse).
- Parses framed host commands into single-byte EEPROM read/write operations for the I2C EEPROM controller.
- Buffers write payload internally, checks the frame checksum, then issues operations one at a time over a valid/ready handshake.

Parameters:
- MAX_LEN, 16, maximum payload/operation count per frame (1..255).
- HEADER, 8'hA5, frame start byte.
- TIMEOUT, 50000, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  received byte from UART receiver
- rx_vld  input  1  one-cycle pulse, rx_data valid
- op_vld  output  1  operation request valid
- op_rdy  input  1  controller accepts the operation when op_vld && op_rdy
- op_rw  output  1  0 = write, 1 = read
- op_addr  output  8  EEPROM byte address
- op_wdata  output  8  write data; 0 for reads
- busy  output  1  high from the header byte to the cycle after the last operation is accepted
- done  output  1  one-cycle pulse after the final operation of a frame is accepted
- err  output  1  one-cycle pulse on a frame error
- err_code  output  2  0 = checksum, 1 = bad CMD, 2 = bad LEN, 3 = timeout; holds its last value

Behaviour:
- Reset: all outputs 0, FSM in IDLE, buffer contents don't-care.
- Frame format: HEADER, CMD (8'h01 = WR, 8'h02 = RD), ADDR, LEN, DATA[LEN] (WR only), CHK.
- CHK is the XOR of CMD, ADDR, LEN and all DATA bytes.
- States: IDLE, CMD, ADDR, LEN, DATA, CHK, ISSUE.
- Transitions on rx_vld only, except ISSUE:
  - IDLE: byte == HEADER -> CMD; any other byte is ignored.
  - CMD: 01/02 -> ADDR; otherwise err with code 1 -> IDLE.
  - ADDR -> LEN.
  - LEN: value 0 or > MAX_LEN -> err with code 2 -> IDLE; else WR -> DATA, RD -> CHK.
  - DATA: store byte at buffer[index]; after LEN bytes -> CHK.
  - CHK: match -> ISSUE; mismatch -> err with code 0 -> IDLE. No operation is issued for a failed frame.
- ISSUE:
  - op_vld asserts the cycle after entering ISSUE.
  - op_rw, op_addr and op_wdata stay stable while op_vld is high and op_rdy is low.
  - On acceptance: op_addr increments mod 256 (8'hFF -> 8'h00) and the next operation is presented in the following cycle. op_vld may stay high back-to-back, giving 1 operation per cycle when op_rdy is held high.
  - After the LEN-th acceptance: op_vld deasserts, done pulses, busy falls, FSM -> IDLE.
- rx_vld during ISSUE: byte dropped, no other effect.
- A HEADER byte in any parse state other than IDLE is treated as data, not as a resync.
- err and done never pulse in the same cycle.
- Reset mid-frame or mid-ISSUE: immediate return to IDLE with outputs 0; a pending operation is abandoned.
- Counters: index/operation counter is $clog2(MAX_LEN+1) bits; running XOR is 8 bits; address register is 8 bits.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on every rx_vld and counts while in CMD..CHK.
  - When the count reaches TIMEOUT-1 with no byte received: err pulses with code 3 and the FSM returns to IDLE.
  - The counter is idle in IDLE and ISSUE.
- Undefined: no counter is built; the parser waits indefinitely; err_code 3 is never produced.

Test Plan:
- WR frame A5 01 10 02 11 22 with CHK = 01^10^02^11^22 = 0x20, op_rdy held at 1 -> two consecutive ops (rw = 0, addr 0x10/0x11, data 0x11/0x22), then a done pulse; busy high throughout.
- RD frame A5 02 FE 03 with CHK = 0xFF, op_rdy low 5 cycles before each accept -> three reads at addr FE, FF, 00 with op fields stable while stalled; op_wdata = 0; done after the third acceptance.
- WR frame with CHK corrupted (0x21 instead of 0x20) -> err with err_code = 0, no op_vld, next valid frame processed normally.
- CMD = 0x07 -> err code 1; LEN = 0 -> err code 2; LEN = MAX_LEN+1 -> err code 2; garbage bytes in IDLE ignored with no err.
- Bytes sent during ISSUE are dropped; rst_n asserted mid-ISSUE -> op_vld, busy and done are 0 immediately, and FSM restarts cleanly.
- With CMD_TIMEOUT_EN and TIMEOUT = 100: send A5 01 then stall 100 cycles -> err code 3 and return to IDLE; without the macro, the same stall gives no err and the frame completes when its remaining bytes arrive.
